// File: rtl/time_setter.sv
// Time-setting front end for a BCD mm:ss counter: debounces two push-buttons
// and walks a shadow copy of the time through per-digit edit states before loading it.
module time_setter #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_mX,
  input  logic [3:0] cur_mU,
  input  logic [3:0] cur_sX,
  input  logic [3:0] cur_sU,
  output logic [3:0] set_mX,
  output logic [3:0] set_mU,
  output logic [3:0] set_sX,
  output logic [3:0] set_sU,
  output logic       load,
  output logic       editing,
  output logic [3:0] edit_sel
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    EDIT_MX,
    EDIT_MU,
    EDIT_SX,
    EDIT_SU,
    COMMIT
  } state_t;

  // Bit 0 carries the mode button, bit 1 the increment button.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];

  logic mode_press;
  logic inc_press;

  state_t     state;
  state_t     state_nx;
  logic [3:0] shadow    [4];
  logic [3:0] shadow_nx [4];

  assign raw = {btn_inc, btn_mode};

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb_q <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  assign press      = deb & ~deb_q;
  assign mode_press = press[0];
  assign inc_press  = press[1];

  function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      for (int unsigned i = 0; i < 4; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      state <= state_nx;
      for (int unsigned i = 0; i < 4; i++) begin
        shadow[i] <= shadow_nx[i];
      end
    end
  end

  // Mode is tested before inc in every edit state, so a coincident inc is dropped.
  always_comb begin
    state_nx = state;
    for (int unsigned i = 0; i < 4; i++) begin
      shadow_nx[i] = shadow[i];
    end
    unique case (state)
      IDLE: begin
        if (mode_press) begin
          state_nx     = EDIT_MX;
          shadow_nx[0] = cur_mX;
          shadow_nx[1] = cur_mU;
          shadow_nx[2] = cur_sX;
          shadow_nx[3] = cur_sU;
        end
      end
      EDIT_MX: begin
        if (mode_press)     state_nx = EDIT_MU;
        else if (inc_press) shadow_nx[0] = bump(shadow[0], 4'd5);
      end
      EDIT_MU: begin
        if (mode_press)     state_nx = EDIT_SX;
        else if (inc_press) shadow_nx[1] = bump(shadow[1], 4'd9);
      end
      EDIT_SX: begin
        if (mode_press)     state_nx = EDIT_SU;
        else if (inc_press) shadow_nx[2] = bump(shadow[2], 4'd5);
      end
      EDIT_SU: begin
        if (mode_press)     state_nx = COMMIT;
        else if (inc_press) shadow_nx[3] = bump(shadow[3], 4'd9);
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    edit_sel = '0;
    unique case (state)
      EDIT_MX: edit_sel = 4'b1000;
      EDIT_MU: edit_sel = 4'b0100;
      EDIT_SX: edit_sel = 4'b0010;
      EDIT_SU: edit_sel = 4'b0001;
      default: edit_sel = '0;
    endcase
  end

  assign load    = (state == COMMIT);
  assign editing = (state == EDIT_MX) || (state == EDIT_MU) ||
                   (state == EDIT_SX) || (state == EDIT_SU);

  assign set_mX = shadow[0];
  assign set_mU = shadow[1];
  assign set_sX = shadow[2];
  assign set_sU = shadow[3];

endmodule

// File: tb/tb_time_setter.sv
// Bench for time_setter: directed scenarios plus random button activity,
// every cycle checked against a history-window model of the debouncer and edit flow.
module tb_time_setter;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_mX, cur_mU, cur_sX, cur_sU;
  logic [3:0] set_mX, set_mU, set_sX, set_sU;
  logic       load;
  logic       editing;
  logic [3:0] edit_sel;

  int total = 0;
  int bad   = 0;

  time_setter #(.DEBOUNCE_CYCLES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .cur_mX   (cur_mX),
    .cur_mU   (cur_mU),
    .cur_sX   (cur_sX),
    .cur_sU   (cur_sU),
    .set_mX   (set_mX),
    .set_mU   (set_mU),
    .set_sX   (set_sX),
    .set_sU   (set_sU),
    .load     (load),
    .editing  (editing),
    .edit_sel (edit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: raw sample history per button (index 0 = newest edge), debounced
  // level, stage 0=idle, 1..4=editing digit st-1, 5=commit; digits in an array.
  bit hist      [2][N+2];
  bit mdeb      [2];
  bit mdeb_prev [2];
  int mst = 0;
  int dig [4] = '{0, 0, 0, 0};
  int lim [4] = '{5, 9, 5, 9};

  // At each negedge: compare what the last posedge produced, then predict the
  // next posedge from the inputs that are stable across it.
  always @(negedge clk) begin
    logic [3:0]  esel;
    logic [17:0] exp_v, act_v;
    bit          mp, ip, diff;
    bit          rawb [2];
    esel  = (mst >= 1 && mst <= 4) ? (4'b1000 >> (mst - 1)) : 4'b0000;
    exp_v = {mst == 5, mst >= 1 && mst <= 4, 4'(dig[0]), 4'(dig[1]), 4'(dig[2]), 4'(dig[3])};
    act_v = {load, editing, set_mX, set_mU, set_sX, set_sU};
    total++;
    if (act_v !== exp_v || edit_sel !== esel) begin
      bad++;
      $display("FAIL cycle_cmp t=%0t got load=%b editing=%b sel=%b set=%h%h%h%h expected load=%b editing=%b sel=%b set=%h",
               $time, load, editing, edit_sel, set_mX, set_mU, set_sX, set_sU,
               exp_v[17], exp_v[16], esel, exp_v[15:0]);
    end

    rawb[0] = btn_mode;
    rawb[1] = btn_inc;
    if (!reset) begin
      mst = 0;
      for (int d = 0; d < 4; d++) dig[d] = 0;
      for (int b = 0; b < 2; b++) begin
        mdeb[b] = 0;
        mdeb_prev[b] = 0;
        for (int i = 0; i < N + 2; i++) hist[b][i] = 0;
      end
    end else begin
      mp = mdeb[0] && !mdeb_prev[0];
      ip = mdeb[1] && !mdeb_prev[1];
      if (mst == 5) begin
        mst = 0;
      end else if (mp) begin
        if (mst == 0) begin
          dig[0] = cur_mX; dig[1] = cur_mU; dig[2] = cur_sX; dig[3] = cur_sU;
        end
        mst = mst + 1;
      end else if (ip && mst >= 1 && mst <= 4) begin
        dig[mst-1] = (dig[mst-1] >= lim[mst-1]) ? 0 : dig[mst-1] + 1;
      end
      for (int b = 0; b < 2; b++) begin
        mdeb_prev[b] = mdeb[b];
        for (int i = N + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = rawb[b];
        // The synchronizer delays samples two edges; flip after N disagreeing ones.
        diff = 1;
        for (int i = 2; i < N + 2; i++) if (hist[b][i] == mdeb[b]) diff = 0;
        if (diff) mdeb[b] = !mdeb[b];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic press(input bit which_inc);
    if (which_inc) btn_inc = 1'b1;
    else           btn_mode = 1'b1;
    step(N + 6);
    btn_inc  = 1'b0;
    btn_mode = 1'b0;
    step(N + 4);
  endtask

  initial begin
    int k_edit, loads;
    logic [15:0] set_at_load;
    reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cur_mX = 4'd0; cur_mU = 4'd0; cur_sX = 4'd0; cur_sU = 4'd0;

    step(3);
    chk("reset_outputs", {14'd0, load, editing, edit_sel, set_mX, set_mU, set_sX, set_sU}, 32'd0);
    reset = 1'b1;
    step(2);
    btn_mode = 1'b1;
    step(3);
    btn_mode = 1'b0;
    step(12);
    chk("glitch_idle", {26'd0, editing, load, edit_sel}, 32'd0);

    cur_mX = 4'd1; cur_mU = 4'd2; cur_sX = 4'd3; cur_sU = 4'd4;
    btn_mode = 1'b1;
    k_edit = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 10) btn_mode = 1'b0;
      if (editing && k_edit < 0) k_edit = k;
    end
    chk("entry_latency", k_edit, 7);
    chk("entry_sel", edit_sel, 4'b1000);
    chk("entry_set", {set_mX, set_mU, set_sX, set_sU}, 16'h1234);
    cur_mX = 4'd7; cur_mU = 4'd7; cur_sX = 4'd7; cur_sU = 4'd7;

    repeat (4) press(1'b1);
    chk("mx_to_5", {set_mX, set_mU, set_sX, set_sU}, 16'h5234);
    press(1'b1);
    chk("mx_wrap", {set_mX, set_mU, set_sX, set_sU}, 16'h0234);

    press(1'b0);
    chk("sel_mu", edit_sel, 4'b0100);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step(N + 6);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(N + 4);
    chk("simul_sel", edit_sel, 4'b0010);
    chk("simul_mu", set_mU, 4'd2);

    press(1'b0);
    chk("sel_su", edit_sel, 4'b0001);
    repeat (5) press(1'b1);
    chk("su_to_9", set_sU, 4'd9);
    repeat (5) press(1'b1);
    chk("su_wrap10", {set_mX, set_mU, set_sX, set_sU}, 16'h0234);

    btn_mode = 1'b1;
    loads = 0;
    set_at_load = '0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 10) btn_mode = 1'b0;
      if (load) begin
        loads++;
        set_at_load = {set_mX, set_mU, set_sX, set_sU};
      end
    end
    chk("commit_loads", loads, 1);
    chk("commit_set", set_at_load, 16'h0234);
    chk("after_commit", {26'd0, editing, load, edit_sel}, 32'd0);

    cur_mX = 4'd5; cur_mU = 4'd9; cur_sX = 4'd0; cur_sU = 4'd1;
    press(1'b0);
    press(1'b0);
    press(1'b0);
    chk("sel_sx", edit_sel, 4'b0010);
    chk("mid_set", {set_mX, set_mU, set_sX, set_sU}, 16'h5901);
    reset = 1'b0;
    loads = 0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (load) loads++;
    end
    reset = 1'b1;
    step(2);
    if (load) loads++;
    chk("reset_noload", loads, 0);
    chk("reset_clear", {14'd0, load, editing, edit_sel, set_mX, set_mU, set_sX, set_sU}, 32'd0);

    btn_mode = 1'b1;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(N + 4);
    chk("held_through_reset", edit_sel, 4'b1000);
    btn_mode = 1'b0;
    step(N + 4);

    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cur_mX = 4'($urandom_range(0, 15));
      cur_mU = 4'($urandom_range(0, 15));
      cur_sX = 4'($urandom_range(0, 15));
      cur_sU = 4'($urandom_range(0, 15));
      if (r < 4) begin
        reset = 1'b0;
        step(int'($urandom_range(1, 3)));
        reset = 1'b1;
      end else begin
        btn_mode = ($urandom_range(0, 2) == 0);
        btn_inc  = ($urandom_range(0, 1) == 0);
        step(int'($urandom_range(1, 12)));
      end
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
